// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, receiver states
// and the clocks-per-bit derivation used to size the baud counter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received words; a write lands in the array in one cycle and is readable the next.
// A push into a full FIFO is refused unless a pop happens in the same cycle; the head is held while not popped.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] last_word;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // When empty, keep presenting the most recently popped word rather than a stale slot.
    assign pop_data = empty ? last_word : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_word <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last_word <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit sampling, glitch/break handling and a word FIFO.
// Word appears on rx_valid one cycle after the final stop sample; a full FIFO drops the word and pulses overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS + 1);

    rx_state_t              state;
    logic [1:0]             sync;
    logic                   rxs;
    logic                   rxs_prev;
    logic [1:0]             settle;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bitn;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr;
    logic                   ferr;
    logic                   fall;
    logic                   tick;
    logic                   push;
    logic                   stop_ferr;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [DATA_BITS+1:0]   head;

    assign rxs       = sync[1];
    // settle masks the edge the reset-to-1 synchroniser would fake if the line is low at release.
    assign fall      = (settle == 2'd3) && rxs_prev && !rxs;
    assign tick      = (cnt == CW'(CPB - 1));
    assign stop_ferr = ferr | ~rxs;
    assign push      = (state == STOP) && tick && (bitn == BW'(STOP_BITS - 1));
    assign pop       = rx_valid && rx_ready;
    assign rx_valid  = !empty;
    assign rx_ferr   = head[DATA_BITS+1];
    assign rx_perr   = head[DATA_BITS];
    assign rx_data   = head[DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            rxs_prev <= 1'b1;
            settle   <= 2'd0;
            state    <= IDLE;
            cnt      <= '0;
            bitn     <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sync     <= {sync[0], rx_in};
            rxs_prev <= rxs;
            if (settle != 2'd3) settle <= settle + 2'd1;
            overrun  <= push && full && !pop;
            cnt      <= tick ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    bitn <= '0;
                    perr <= 1'b0;
                    ferr <= 1'b0;
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CW'(CPB / 2 - 1)) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bitn == BW'(DATA_BITS - 1)) begin
                            bitn  <= '0;
                            state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            bitn <= bitn + BW'(1);
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        perr  <= ((^shreg) ^ rxs) != (PARITY == PAR_ODD);
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        ferr <= stop_ferr;
                        if (bitn == BW'(STOP_BITS - 1)) begin
                            bitn <= '0;
                            if (stop_ferr && (shreg == '0)) begin
                                state <= BREAK;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bitn <= bitn + BW'(1);
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({stop_ferr, perr, shreg}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance at the default 234 clk/bit and an 8E2 instance at 16 clk/bit.
// Words are expected as {ferr, perr, data}; random frames are scored against an arithmetic frame model.
module tb_uart_rx_param;

    localparam int CPB_A = 234;
    localparam int CPB_B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       valid_a, valid_b, overrun_a, overrun_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] got_a [0:255];
    logic [9:0] got_b [0:255];
    int na = 0, nb = 0, ovr_a = 0, ovr_b = 0;
    int ra = 0, rb = 0;

    always #5 clk = ~clk;

    uart_rx_param dut_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .rx_data(data_a), .rx_perr(perr_a),
        .rx_ferr(ferr_a), .rx_valid(valid_a), .rx_ready(ready_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .rx_data(data_b), .rx_perr(perr_b),
        .rx_ferr(ferr_b), .rx_valid(valid_b), .rx_ready(ready_b), .overrun(overrun_b), .busy(busy_b)
    );

    // Consumer side: record every accepted word and every overrun pulse.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin got_a[na[7:0]] <= {ferr_a, perr_a, data_a}; na <= na + 1; end
        if (valid_b && ready_b) begin got_b[nb[7:0]] <= {ferr_b, perr_b, data_b}; nb <= nb + 1; end
        if (overrun_a) ovr_a <= ovr_a + 1;
        if (overrun_b) ovr_b <= ovr_b + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       s0;
        logic       s1;
        logic [9:0] exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_b = bits[i]; else rx_a = bits[i];
            cycles(cpb);
        end
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
        cycles(4);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        send_bits(1'b0, {6'b0, stop, d, 1'b0}, 10, CPB_A);
    endtask

    task automatic send_b(input logic [7:0] d, input logic pbit, input logic s0, input logic s1);
        send_bits(1'b1, {4'b0, s1, s0, pbit, d, 1'b0}, 12, CPB_B);
    endtask

    task automatic expect_word(input bit sel, input logic [9:0] exp, input string name);
        int waited = 0;
        while (!(sel ? (rb < nb) : (ra < na)) && waited < 1000) begin
            cycles(1);
            waited++;
        end
        if (sel ? (rb < nb) : (ra < na)) begin
            check(name, sel ? int'(got_b[rb[7:0]]) : int'(got_a[ra[7:0]]), int'(exp));
            if (sel) rb++; else ra++;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no word received, expected 0x%0h", name, exp);
        end
    endtask

    // Frame model: even parity wants an even count of ones over data plus parity bit;
    // any low stop bit is a framing error.
    function automatic logic [9:0] model_b(input logic [7:0] d, input logic pbit, input logic s0, input logic s1);
        logic pe, fe;
        pe = ((($countones(d) + int'(pbit)) % 2) != 0);
        fe = !(s0 && s1);
        return {fe, pe, d};
    endfunction

    initial begin
        vec_t vecs[8];
        int   base_n, base_o;

        vecs[0] = '{8'hA3, 1'b1, 1'b1, 1'b1, 10'h1A3};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b1, 10'h0A3};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b1, 10'h001};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 10'h101};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 10'h0FF};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 10'h25A};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b1, 10'h23C};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 10'h080};

        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("reset rx_valid", int'(valid_a), 0);
        check("reset overrun", int'(overrun_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset rx_perr", int'(perr_a), 0);
        check("reset rx_ferr", int'(ferr_a), 0);
        check("reset rx_data", int'(data_a), 0);

        // 8E2 table vectors
        for (int i = 0; i < 8; i++) begin
            send_b(vecs[i].d, vecs[i].pbit, vecs[i].s0, vecs[i].s1);
            expect_word(1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // 8E2 random frames against the model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic       p, s0, s1;
            d  = 8'($urandom_range(0, 255));
            p  = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 9) != 0);
            s1 = ($urandom_range(0, 9) != 0);
            send_b(d, p, s0, s1);
            cycles($urandom_range(0, 20));
            expect_word(1'b1, model_b(d, p, s0, s1), $sformatf("rand%0d", i));
        end
        check("b overrun count", ovr_b, 0);

        // 8N1 basic frame: exactly one word
        send_a(8'h55, 1'b1);
        expect_word(1'b0, 10'h055, "8n1 0x55");
        cycles(50);
        check("8n1 single word", na, ra);

        // Start-bit glitch
        base_n = na;
        base_o = ovr_a;
        rx_a = 1'b0;
        cycles(20);
        check("glitch busy high", int'(busy_a), 1);
        cycles(30);
        rx_a = 1'b1;
        cycles(300);
        check("glitch busy low", int'(busy_a), 0);
        check("glitch no word", na - base_n, 0);
        check("glitch no overrun", ovr_a - base_o, 0);

        // Framing error
        send_a(8'h41, 1'b0);
        expect_word(1'b0, 10'h241, "ferr 0x41");

        // Break: 20 bit-times low yields one word, then normal reception resumes
        base_n = na;
        rx_a = 1'b0;
        cycles(15 * CPB_A);
        check("break busy", int'(busy_a), 1);
        cycles(5 * CPB_A);
        rx_a = 1'b1;
        cycles(10);
        check("break busy released", int'(busy_a), 0);
        check("break word count", na - base_n, 1);
        expect_word(1'b0, 10'h200, "break word");
        send_a(8'h42, 1'b1);
        expect_word(1'b0, 10'h042, "after break 0x42");

        // FIFO fill with no consumer: fifth word overruns
        ready_a = 1'b0;
        base_o = ovr_a;
        base_n = na;
        for (int i = 0; i < 5; i++) send_a(8'h10 + 8'(i), 1'b1);
        cycles(10);
        check("overrun pulses", ovr_a - base_o, 1);
        check("full head valid", int'(valid_a), 1);
        check("full head data", int'(data_a), 8'h10);
        ready_a = 1'b1;
        cycles(10);
        check("drain count", na - base_n, 4);
        for (int i = 0; i < 4; i++) expect_word(1'b0, 10'h010 + 10'(i), $sformatf("drain%0d", i));
        check("drained rx_valid", int'(valid_a), 0);

        // Reset in the middle of 0x7E's data bits; line still low at release
        base_n = na;
        rx_a = 1'b0;
        cycles(CPB_A + CPB_A / 2);
        check("mid-frame busy", int'(busy_a), 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(CPB_A);
        check("post-reset busy", int'(busy_a), 0);
        rx_a = 1'b1;
        cycles(3 * CPB_A);
        check("post-reset no word", na - base_n, 0);
        send_a(8'h33, 1'b1);
        expect_word(1'b0, 10'h033, "post-reset 0x33");
        cycles(20);
        check("post-reset word count", na - base_n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
